// File: rtl/detection_unit.sv
// Hazard detection and forwarding select for the 3-wide ID stage: compares the ID
// group against itself, EX and MEM, and squashes the youngest slots that cannot issue.
package detection_unit_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    FORWARD_NONE  = 3'd0,
    FORWARD_EX_0  = 3'd1,
    FORWARD_EX_1  = 3'd2,
    FORWARD_EX_2  = 3'd3,
    FORWARD_MEM_0 = 3'd4,
    FORWARD_MEM_1 = 3'd5,
    FORWARD_MEM_2 = 3'd6
  } FORWARDING_TYPE;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  alu_func;
    logic [4:0]  dest_reg_idx;
    logic        rd_mem;
    logic        wr_mem;
    logic        cond_branch;
    logic        uncond_branch;
    logic        halt;
    logic        illegal;
    logic        valid;
  } ID_EX_PACKET;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] npc;
    logic [4:0]  dest_reg_idx;
    logic        rd_mem;
    logic        wr_mem;
    logic        halt;
    logic        illegal;
    logic        valid;
  } EX_MEM_PACKET;

endpackage

module detection_unit
  import detection_unit_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  ID_EX_PACKET          id_packet_0,
  input  ID_EX_PACKET          id_packet_1,
  input  ID_EX_PACKET          id_packet_2,
  input  ID_EX_PACKET          ex_packet_0,
  input  ID_EX_PACKET          ex_packet_1,
  input  ID_EX_PACKET          ex_packet_2,
  input  EX_MEM_PACKET         mem_packet_0,
  input  EX_MEM_PACKET         mem_packet_1,
  input  EX_MEM_PACKET         mem_packet_2,
  output ID_EX_PACKET          id_packet_out_0,
  output ID_EX_PACKET          id_packet_out_1,
  output ID_EX_PACKET          id_packet_out_2,
  output logic [1:0]           rollback,
  output FORWARDING_TYPE [2:0] forwarding_A,
  output FORWARDING_TYPE [2:0] forwarding_B
);

  ID_EX_PACKET id     [3];
  ID_EX_PACKET id_out [3];
  logic [14:0] ex_dest;
  logic [14:0] mem_dest;
  logic [2:0]  ex_load;
  logic [2:0]  dep;
  logic [4:0]  rs1 [3];
  logic [4:0]  rs2 [3];

  assign id[0]    = id_packet_0;
  assign id[1]    = id_packet_1;
  assign id[2]    = id_packet_2;
  assign ex_dest  = {ex_packet_2.dest_reg_idx, ex_packet_1.dest_reg_idx, ex_packet_0.dest_reg_idx};
  assign mem_dest = {mem_packet_2.dest_reg_idx, mem_packet_1.dest_reg_idx, mem_packet_0.dest_reg_idx};
  assign ex_load  = {ex_packet_2.rd_mem, ex_packet_1.rd_mem, ex_packet_0.rd_mem};

  // The block is stateless; clock, reset and the unused packet fields are folded here.
  logic unused_inputs;
  assign unused_inputs = ^{clock, reset, ex_packet_0, ex_packet_1, ex_packet_2,
                           mem_packet_0, mem_packet_1, mem_packet_2};

  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH);
  endfunction

  // Later assignments override earlier ones, so EX_2 ends up with the highest priority.
  function automatic FORWARDING_TYPE fwd_sel(input logic [4:0] r, input logic [14:0] exd,
                                             input logic [14:0] memd);
    fwd_sel = FORWARD_NONE;
    if (r != 5'd0) begin
      if (memd[4:0]   == r) fwd_sel = FORWARD_MEM_0;
      if (memd[9:5]   == r) fwd_sel = FORWARD_MEM_1;
      if (memd[14:10] == r) fwd_sel = FORWARD_MEM_2;
      if (exd[4:0]    == r) fwd_sel = FORWARD_EX_0;
      if (exd[9:5]    == r) fwd_sel = FORWARD_EX_1;
      if (exd[14:10]  == r) fwd_sel = FORWARD_EX_2;
    end
  endfunction

  // A younger non-load EX writer shadows an older load to the same register.
  function automatic logic load_hit(input logic [4:0] r, input logic [14:0] exd,
                                    input logic [2:0] exl);
    load_hit = 1'b0;
    if (r != 5'd0) begin
      for (int i = 0; i < 3; i++) begin
        if (exd[5*i +: 5] == r) load_hit = exl[i];
      end
    end
  endfunction

  always_comb begin
    dep = '0;
    for (int j = 0; j < 3; j++) begin
      // An unread operand is mapped to x0 so it can never match a writer.
      rs1[j] = reads_rs1(id[j].inst[6:0]) ? id[j].inst[19:15] : 5'd0;
      rs2[j] = reads_rs2(id[j].inst[6:0]) ? id[j].inst[24:20] : 5'd0;
      forwarding_A[j] = fwd_sel(rs1[j], ex_dest, mem_dest);
      forwarding_B[j] = fwd_sel(rs2[j], ex_dest, mem_dest);
      if (load_hit(rs1[j], ex_dest, ex_load) || load_hit(rs2[j], ex_dest, ex_load))
        dep[j] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (i < j) begin
          if (rs1[j] != 5'd0 && id[i].dest_reg_idx == rs1[j]) dep[j] = 1'b1;
          if (rs2[j] != 5'd0 && id[i].dest_reg_idx == rs2[j]) dep[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (dep[0])      rollback = 2'd3;
    else if (dep[1]) rollback = 2'd2;
    else if (dep[2]) rollback = 2'd1;
    else             rollback = 2'd0;
  end

  // Once any slot is dependent, it and every younger slot become bubbles.
  always_comb begin
    logic squash;
    squash = 1'b0;
    for (int j = 0; j < 3; j++) begin
      squash    = squash | dep[j];
      id_out[j] = id[j];
      if (squash) begin
        id_out[j].inst          = NOP;
        id_out[j].valid         = 1'b0;
        id_out[j].dest_reg_idx  = 5'd0;
        id_out[j].rd_mem        = 1'b0;
        id_out[j].wr_mem        = 1'b0;
        id_out[j].cond_branch   = 1'b0;
        id_out[j].uncond_branch = 1'b0;
        id_out[j].halt          = 1'b0;
        id_out[j].illegal       = 1'b0;
      end
    end
  end

  assign id_packet_out_0 = id_out[0];
  assign id_packet_out_1 = id_out[1];
  assign id_packet_out_2 = id_out[2];

endmodule

// File: tb/tb_detection_unit.sv
// Randomized and directed bench for detection_unit: a driver pushes reference-model
// expectations into a queue, a monitor on the falling edge pops and compares.
module tb_detection_unit;
  import detection_unit_pkg::*;

  typedef struct packed {
    logic [1:0]  rb;
    logic [8:0]  fa;
    logic [8:0]  fb;
    ID_EX_PACKET o0;
    ID_EX_PACKET o1;
    ID_EX_PACKET o2;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  ID_EX_PACKET  id0, id1, id2, ex0, ex1, ex2;
  EX_MEM_PACKET mem0, mem1, mem2;
  ID_EX_PACKET  out0, out1, out2;
  logic [1:0]   rollback;
  FORWARDING_TYPE [2:0] fwd_a, fwd_b;

  ID_EX_PACKET  m_id  [3];
  ID_EX_PACKET  m_ex  [3];
  EX_MEM_PACKET m_mem [3];
  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  detection_unit dut (
    .clock(clock), .reset(reset),
    .id_packet_0(id0), .id_packet_1(id1), .id_packet_2(id2),
    .ex_packet_0(ex0), .ex_packet_1(ex1), .ex_packet_2(ex2),
    .mem_packet_0(mem0), .mem_packet_1(mem1), .mem_packet_2(mem2),
    .id_packet_out_0(out0), .id_packet_out_1(out1), .id_packet_out_2(out2),
    .rollback(rollback), .forwarding_A(fwd_a), .forwarding_B(fwd_b)
  );

  // clock / reset
  always #5 clock = ~clock;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] i_add(input int rd, input int rs1, input int rs2);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] i_lw(input int rd, input int rs1);
    return {12'd0, rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
  endfunction

  function automatic ID_EX_PACKET mk(input logic [31:0] inst);
    ID_EX_PACKET p;
    p = '0;
    p.inst        = inst;
    p.pc          = $urandom;
    p.npc         = p.pc + 32'd4;
    p.alu_func    = 5'($urandom_range(0, 31));
    p.valid       = 1'b1;
    p.rd_mem      = (inst[6:0] == 7'b0000011);
    p.wr_mem      = (inst[6:0] == OPC_STORE);
    p.cond_branch = (inst[6:0] == OPC_BRANCH);
    p.uncond_branch = (inst[6:0] == OPC_JAL || inst[6:0] == 7'b1100111);
    p.dest_reg_idx = (inst[6:0] == OPC_STORE || inst[6:0] == OPC_BRANCH) ? 5'd0 : inst[11:7];
    return p;
  endfunction

  function automatic EX_MEM_PACKET mk_mem(input int rd);
    EX_MEM_PACKET p;
    p = '0;
    p.dest_reg_idx = rd[4:0];
    p.alu_result   = $urandom;
    p.valid        = (rd != 0);
    return p;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] opc;
    logic [6:0] ops [9];
    ops = '{OPC_OP, 7'b0010011, 7'b0000011, OPC_STORE, OPC_BRANCH,
            OPC_LUI, OPC_AUIPC, OPC_JAL, 7'b1100111};
    opc = ops[$urandom_range(0, 8)];
    return {7'($urandom_range(0, 127)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 5)), opc};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [4:0] read_reg(input logic [31:0] inst, input int which);
    logic [6:0] op;
    op = inst[6:0];
    if (which == 1)
      return (op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL) ? 5'd0 : inst[19:15];
    return (op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH) ? inst[24:20] : 5'd0;
  endfunction

  // Priority-ordered producer list: EX_2, EX_1, EX_0, MEM_2, MEM_1, MEM_0.
  task automatic lookup(input logic [4:0] r, output FORWARDING_TYPE sel, output logic load);
    FORWARDING_TYPE codes [6];
    logic [4:0] dst;
    logic found;
    codes = '{FORWARD_EX_2, FORWARD_EX_1, FORWARD_EX_0,
              FORWARD_MEM_2, FORWARD_MEM_1, FORWARD_MEM_0};
    sel = FORWARD_NONE;
    load = 1'b0;
    found = 1'b0;
    for (int s = 0; s < 6; s++) begin
      dst = (s < 3) ? m_ex[2-s].dest_reg_idx : m_mem[5-s].dest_reg_idx;
      if (!found && r != 5'd0 && dst == r) begin
        found = 1'b1;
        sel = codes[s];
        load = (s < 3) && m_ex[2-s].rd_mem;
      end
    end
  endtask

  function automatic ID_EX_PACKET bubble(input ID_EX_PACKET p);
    ID_EX_PACKET b;
    b = p;
    b.inst = NOP; b.valid = 1'b0; b.dest_reg_idx = 5'd0;
    b.rd_mem = 1'b0; b.wr_mem = 1'b0; b.cond_branch = 1'b0;
    b.uncond_branch = 1'b0; b.halt = 1'b0; b.illegal = 1'b0;
    return b;
  endfunction

  task automatic model(output exp_t e);
    int first_dep;
    int keep;
    FORWARDING_TYPE sa, sb;
    logic la, lb;
    logic [4:0] ra, rb;
    ID_EX_PACKET outs [3];
    first_dep = 3;
    e = '0;
    for (int j = 0; j < 3; j++) begin
      ra = read_reg(m_id[j].inst, 1);
      rb = read_reg(m_id[j].inst, 2);
      lookup(ra, sa, la);
      lookup(rb, sb, lb);
      e.fa[3*j +: 3] = sa;
      e.fb[3*j +: 3] = sb;
      if (la || lb) first_dep = (j < first_dep) ? j : first_dep;
      for (int i = 0; i < j; i++) begin
        if ((ra != 0 && m_id[i].dest_reg_idx == ra) || (rb != 0 && m_id[i].dest_reg_idx == rb))
          first_dep = (j < first_dep) ? j : first_dep;
      end
    end
    e.rb = (first_dep == 3) ? 2'd0 : 2'(3 - first_dep);
    keep = 3 - int'(e.rb);
    for (int j = 0; j < 3; j++) outs[j] = (j < keep) ? m_id[j] : bubble(m_id[j]);
    e.o0 = outs[0]; e.o1 = outs[1]; e.o2 = outs[2];
  endtask

  // ---------------- driver ----------------
  // want_rb >= 0 pins the rollback expectation to a hand-derived constant.
  task automatic apply(input logic rst, input int want_rb);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst;
    id0 = m_id[0]; id1 = m_id[1]; id2 = m_id[2];
    ex0 = m_ex[0]; ex1 = m_ex[1]; ex2 = m_ex[2];
    mem0 = m_mem[0]; mem1 = m_mem[1]; mem2 = m_mem[2];
    model(e);
    if (want_rb >= 0) e.rb = 2'(want_rb);
    exp_q.push_back(e);
    vectors++;
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < 3; i++) begin
      m_ex[i] = '0;
      m_mem[i] = '0;
    end
  endtask

  task automatic set_id(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    m_id[0] = mk(a); m_id[1] = mk(b); m_id[2] = mk(c);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, vectors, got, want);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rollback", 128'(rollback), 128'(e.rb));
      check("fwd_A", 128'(fwd_a), 128'(e.fa));
      check("fwd_B", 128'(fwd_b), 128'(e.fb));
      check("out_0", 128'(out0), 128'(e.o0));
      check("out_1", 128'(out1), 128'(e.o1));
      check("out_2", 128'(out2), 128'(e.o2));
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int budget;
    clear_pipe();
    set_id(i_addi(1, 1, 1), i_addi(2, 2, 2), i_addi(3, 3, 3));
    reset = 1'b1;
    apply(1'b1, 0);
    apply(1'b0, 0);

    set_id(i_addi(1, 1, 1), i_addi(2, 1, 1), i_addi(3, 3, 3));
    apply(1'b0, 2);
    set_id(i_addi(1, 1, 1), i_addi(3, 3, 3), i_addi(2, 1, 1));
    apply(1'b0, 1);
    set_id(i_addi(1, 1, 1), i_add(3, 4, 1), i_addi(2, 2, 2));
    apply(1'b0, 2);

    set_id(i_addi(1, 1, 1), i_addi(2, 2, 2), i_addi(3, 3, 3));
    m_ex[0] = mk(i_lw(1, 1)); apply(1'b0, 3);
    m_ex[0] = mk(i_lw(2, 1)); apply(1'b0, 2);
    m_ex[0] = mk(i_lw(3, 1)); apply(1'b0, 1);
    clear_pipe();
    m_ex[1] = mk(i_lw(1, 1)); m_ex[2] = mk(i_addi(1, 1, 1)); apply(1'b0, 0);
    m_ex[1] = mk(i_addi(1, 1, 1)); m_ex[2] = mk(i_lw(1, 1)); apply(1'b0, 3);

    clear_pipe();
    set_id(i_add(3, 1, 2), i_addi(2, 2, 2), i_addi(1, 1, 1));
    m_ex[0] = mk(i_addi(1, 1, 1)); m_ex[1] = mk(i_addi(2, 2, 2));
    apply(1'b0, 0);
    clear_pipe();
    m_mem[0] = mk_mem(1); m_mem[1] = mk_mem(2);
    apply(1'b0, 0);
    clear_pipe();
    m_ex[0] = mk(i_addi(2, 2, 2)); m_mem[0] = mk_mem(1);
    apply(1'b0, 0);

    clear_pipe();
    set_id(i_add(0, 0, 0), i_addi(0, 0, 0), i_add(0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      m_ex[i] = mk(i_lw(0, 0));
      m_mem[i] = mk_mem(0);
    end
    apply(1'b0, 0);
    apply(1'b1, 0);
    apply(1'b0, 0);

    for (int n = 0; n < 400; n++) begin
      set_id(rand_inst(), rand_inst(), rand_inst());
      for (int i = 0; i < 3; i++) begin
        m_ex[i] = ($urandom_range(0, 5) == 0) ? '0 : mk(rand_inst());
        if ($urandom_range(0, 2) == 0) m_ex[i].rd_mem = 1'b1;
        m_mem[i] = mk_mem($urandom_range(0, 6));
        m_id[i].halt = 1'($urandom_range(0, 1));
        m_id[i].illegal = 1'($urandom_range(0, 1));
      end
      apply(1'($urandom_range(0, 7) == 0), -1);
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      @(posedge clock);
      budget++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/detection_unit.md
# detection_unit

Combinational hazard-detection and forwarding-select block for the 3-wide superscalar pipeline, between ID and the ID/EX register. It examines the three decoded instructions in ID (slot 0 oldest, slot 2 youngest) against each other and against the three instructions in EX and in MEM. It then emits per-slot operand forwarding selects, and a rollback count that squashes the youngest slots which cannot issue this cycle.

## Interface
Parameters: none.

- clock  input  1  system clock; no internal state depends on it.
- reset  input  1  synchronous, active-high; no effect on outputs (block is stateless).
- id_packet_0/1/2  input  ID_EX_PACKET  decoded ID-stage instructions; uses `inst`, `dest_reg_idx`, `rd_mem`.
- ex_packet_0/1/2  input  ID_EX_PACKET  instructions currently in EX; uses `dest_reg_idx`, `rd_mem`.
- mem_packet_0/1/2  input  EX_MEM_PACKET  instructions currently in MEM; uses `dest_reg_idx`.
- id_packet_out_0/1/2  output  ID_EX_PACKET  ID packets after squashing.
- rollback  output  2  number of youngest ID slots squashed (0–3).
- forwarding_A  output  FORWARDING_TYPE [2:0]  rs1 source per ID slot.
- forwarding_B  output  FORWARDING_TYPE [2:0]  rs2 source per ID slot.

FORWARDING_TYPE enumerators: FORWARD_NONE, FORWARD_EX_0, FORWARD_EX_1, FORWARD_EX_2, FORWARD_MEM_0, FORWARD_MEM_1, FORWARD_MEM_2.

## Operation
**Writers**
- A packet writes register r iff `dest_reg_idx == r` and r != 0.
- x0 never creates a dependency or a forward.
- Zeroed packets therefore act as bubbles.

**Readers** (decoded from `inst` opcode)
- rs1 is read by all opcodes except LUI, AUIPC and JAL.
- rs2 is read only by OP (R-type), STORE and BRANCH.
- An unread operand always gets forwarding = FORWARD_NONE.

**Intra-group RAW**
- ID slot j (j>0) is dependent if it reads a register written by any older ID slot i<j.

**Load-use**
- For each register read by ID slot j, find the youngest EX writer of that register (slot 2 > 1 > 0).
- If that writer has `rd_mem=1`, slot j is load-dependent.
- If a younger EX non-load writes the same register, there is no hazard; that writer is forwarded instead.

**rollback**
- Let k be the oldest ID slot that is intra-group dependent or load-dependent.
- rollback = 3−k (slot 0 → 3, slot 1 → 2, slot 2 → 1).
- rollback = 0 if no slot is dependent.

**id_packet_out_j**
- Equals id_packet_j when j < 3−rollback.
- Otherwise it is the NOP bubble:
  - inst=`NOP, valid=0, dest_reg_idx=0;
  - rd_mem, wr_mem, cond_branch, uncond_branch, halt and illegal all 0;
  - all other fields copied.

**forwarding_A[j] / forwarding_B[j]**, for the read register r, first match wins:
1. EX_2, EX_1, EX_0 writing r.
2. MEM_2, MEM_1, MEM_0 writing r.
3. Otherwise FORWARD_NONE (register file).

Further forwarding rules:
- Computed for every slot, including squashed ones. Ignored by consumers when squashed.
- A load selected in EX yields FORWARD_EX_n but also forces rollback.

## Timing
- Purely combinational; outputs settle in the same cycle as the inputs, zero latency.
- No registers. reset and clock do not alter any output, and there is no reset value to restore.
- Outputs must be glitch-insensitive: the consumer samples at the ID/EX register edge.
- Simultaneous hazards: the oldest offending slot sets rollback. Load-use and intra-group hazards are treated identically.

## Test plan
1. ID = {addi x1,x1,1; addi x2,x2,2; addi x3,x3,3}, EX/MEM zero -> rollback=0; outputs equal inputs; A = {NONE,NONE,NONE}; B all NONE.
2. Intra-group dependencies:
   - ID = {addi x1,x1,1; addi x2,x1,1; addi x3,x3,3} -> rollback=2; out_1 and out_2 are bubbles.
   - ID = {addi x1,x1,1; addi x3,x3,3; addi x2,x1,1} -> rollback=1.
   - ID = {addi x1,x1,1; add x3,x4,x1; addi x2,x2,2} -> rollback=2 (rs2 dependency).
3. Load-use, ID = {addi x1,x1,1; addi x2,x2,2; addi x3,x3,3}:
   - ex_0 = lw x1,0(x1) -> rollback=3.
   - ex_0 = lw x2 -> rollback=2.
   - ex_0 = lw x3 -> rollback=1.
   - ex_1 = lw x1, ex_2 = addi x1 -> rollback=0, A[0]=EX_2.
   - ex_1 = addi x1, ex_2 = lw x1 -> rollback=3.
4. EX forwarding: ID = {add x3,x1,x2; addi x2,x2,2; addi x1,x1,1}, ex_0 = addi x1, ex_1 = addi x2 -> A = {EX_0, EX_1, EX_0}, B[0] = EX_1, B[1] = B[2] = NONE, rollback=0.
5. MEM forwarding and priority, same ID group:
   - EX empty, mem_0 = x1, mem_1 = x2 -> A[0]=MEM_0, B[0]=MEM_1.
   - ex_0 = x2, mem_0 = x1 -> A[0]=MEM_0, B[0]=EX_0, A[1]=EX_0.
6. x0 and reset: every packet targets and reads x0 -> all NONE, rollback=0. Asserting reset mid-stream leaves outputs unchanged for identical inputs.
